// File: rtl/amstrad_mem_responder_if.sv
// Signal bundle between the CPU/video/SDRAM-backend side (master) and the memory responder (slave).
interface amstrad_mem_responder_if;
  logic [22:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_wait;
  logic [14:0] vram_addr;
  logic        vram_req;
  logic [15:0] vram_din;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_be;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic [15:0] sdram_dout;
  logic        timeout_err;

  modport master (
    output mem_addr, mem_rd, mem_wr, cpu_dout, vram_addr, vram_req, sdram_ack, sdram_dout,
    input  cpu_din, cpu_wait, vram_din, sdram_addr, sdram_din, sdram_be, sdram_we, sdram_req,
           timeout_err
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, cpu_dout, vram_addr, vram_req, sdram_ack, sdram_dout,
    output cpu_din, cpu_wait, vram_din, sdram_addr, sdram_din, sdram_be, sdram_we, sdram_req,
           timeout_err
  );
endinterface

// File: rtl/amstrad_mem_responder.sv
// Arbitrates CPU byte accesses and video word fetches onto one 16-bit SDRAM req/ack channel,
// holding returned data and flagging a stalled backend with a sticky watchdog error.
module amstrad_mem_responder #(
  parameter logic [6:0]  VRAM_BASE = 7'd0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  amstrad_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        rd_q, wr_q, rd_rise, wr_rise, cpu_capture;
  logic        cpu_pend, cpu_we, cpu_lane;
  logic [21:0] cpu_word;
  logic [7:0]  cpu_data;
  logic        vid_pend, vid_start, cpu_start;
  logic [14:0] vid_addr;
  logic [7:0]  wdog;

  logic [7:0]  cpu_din_r;
  logic        cpu_wait_r;
  logic [15:0] vram_din_r;
  logic [21:0] sdram_addr_r;
  logic [15:0] sdram_din_r;
  logic [1:0]  sdram_be_r;
  logic        sdram_we_r, sdram_req_r, timeout_err_r;

  assign rd_rise = bus.mem_rd & ~rd_q;
  assign wr_rise = bus.mem_wr & ~wr_q;
  // A strobe edge is dropped while the previous CPU access is still queued or on the backend.
  assign cpu_capture = (rd_rise | wr_rise) & ~cpu_pend & (state != CPU);
  assign vid_start   = (state == IDLE) & vid_pend;
  assign cpu_start   = (state == IDLE) & ~vid_pend & cpu_pend;

  assign bus.cpu_din     = cpu_din_r;
  assign bus.cpu_wait    = cpu_wait_r;
  assign bus.vram_din    = vram_din_r;
  assign bus.sdram_addr  = sdram_addr_r;
  assign bus.sdram_din   = sdram_din_r;
  assign bus.sdram_be    = sdram_be_r;
  assign bus.sdram_we    = sdram_we_r;
  assign bus.sdram_req   = sdram_req_r;
  assign bus.timeout_err = timeout_err_r;

  // NOTE: every register below uses <= so each branch reads pre-edge values regardless of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      cpu_pend      <= 1'b0;
      cpu_we        <= 1'b0;
      cpu_lane      <= 1'b0;
      cpu_word      <= '0;
      cpu_data      <= '0;
      vid_pend      <= 1'b0;
      vid_addr      <= '0;
      wdog          <= '0;
      cpu_din_r     <= 8'hFF;
      cpu_wait_r    <= 1'b0;
      vram_din_r    <= '0;
      sdram_addr_r  <= '0;
      sdram_din_r   <= '0;
      sdram_be_r    <= 2'b11;
      sdram_we_r    <= 1'b0;
      sdram_req_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      rd_q     <= bus.mem_rd;
      wr_q     <= bus.mem_wr;
      // A pulse arriving as a fetch launches keeps the flag set: it queues one more fetch.
      vid_pend <= bus.vram_req | (vid_pend & ~vid_start);
      if (bus.vram_req) vid_addr <= bus.vram_addr;

      if (cpu_capture) begin
        cpu_pend   <= 1'b1;
        cpu_we     <= wr_rise;
        cpu_word   <= bus.mem_addr[22:1];
        cpu_lane   <= bus.mem_addr[0];
        cpu_data   <= bus.cpu_dout;
        cpu_wait_r <= 1'b1;
      end else if (cpu_start) begin
        cpu_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (vid_start) begin
            state        <= VID;
            sdram_addr_r <= {VRAM_BASE, vid_addr};
            sdram_we_r   <= 1'b0;
            sdram_be_r   <= 2'b11;
            sdram_req_r  <= 1'b1;
            wdog         <= '0;
          end else if (cpu_start) begin
            state        <= CPU;
            sdram_addr_r <= cpu_word;
            sdram_we_r   <= cpu_we;
            sdram_be_r   <= cpu_we ? (cpu_lane ? 2'b10 : 2'b01) : 2'b11;
            sdram_din_r  <= {cpu_data, cpu_data};
            sdram_req_r  <= 1'b1;
            wdog         <= '0;
          end
        end
        VID, CPU: begin
          if (bus.sdram_ack) begin
            sdram_req_r <= 1'b0;
            state       <= IDLE;
            if (state == VID) begin
              vram_din_r <= bus.sdram_dout;
            end else begin
              if (!cpu_we) cpu_din_r <= cpu_lane ? bus.sdram_dout[15:8] : bus.sdram_dout[7:0];
              cpu_wait_r <= 1'b0;
            end
          end else if (wdog == WDOG_LAST) begin
            sdram_req_r   <= 1'b0;
            timeout_err_r <= 1'b1;
            state         <= IDLE;
            if (state == CPU) cpu_wait_r <= 1'b0;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
